async_fifo_wptr_full: RTL and testbench
=======================================

# async_fifo_wptr_full

Write-domain pointer and flag generator for the dual-clock FIFO. It counts accepted writes and provides the binary RAM write address and the Gray-coded write pointer sent to the read domain. It compares against the read pointer already synchronised into the write clock to produce full, almost-full and fill-level outputs. It is the write-side counterpart of the read-side logic and sits between the write-side client, the FIFO RAM and the two pointer synchronisers.

## Interface
- ADDRSIZE, 4, FIFO address width; depth = 2^ADDRSIZE; legal range ≥2
- AFULL_THRESH, 12, fill level at or above which wafull asserts; legal range 1..2^ADDRSIZE
- wclk  in  1  write-domain clock; all state updates on the rising edge
- wrst  in  1  synchronous, active-high reset in the wclk domain
- winc  in  1  write request from the client; data is valid in the same cycle
- wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already double-synchronised into wclk
- wen  out  1  RAM write enable, combinational: winc & ~wfull
- waddr  out  ADDRSIZE  binary RAM write address
- wptr  out  ADDRSIZE+1  Gray write pointer, registered, to the read-domain synchroniser
- wfull  out  1  FIFO full, registered
- wafull  out  1  almost full, registered
- wlevel  out  ADDRSIZE+1  fill level seen from the write side, registered, 0..2^ADDRSIZE
- woverflow  out  1  sticky error, set by a write attempted while full

## Operation
- State: wbin, an ADDRSIZE+1 binary counter, and wptr, its Gray image. waddr = wbin[ADDRSIZE-1:0].
- Next-state values:
  - wbinnext = wbin + (winc & ~wfull), modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
- Read pointer handling: rbin_s = Gray-to-binary of wq2_rptr, computed combinationally as an XOR prefix from the MSB down.
- Full compare: fullnext = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- Level: levelnext = wbinnext - rbin_s, modulo 2^(ADDRSIZE+1). It never exceeds 2^ADDRSIZE for a legal read side.
- Registered on each edge when wrst = 0:
  - wbin <= wbinnext
  - wptr <= wgraynext
  - wfull <= fullnext
  - wlevel <= levelnext
  - wafull <= (levelnext >= AFULL_THRESH)
- woverflow <= woverflow | (winc & wfull). It is cleared only by wrst.
- Full flag behaviour:
  - A write while wfull = 1 is dropped: wen = 0 and the pointer holds.
  - Full is pessimistic. It clears only after the read pointer change has crossed the synchroniser, so it never under-reports.
- Simultaneous write accept and wq2_rptr change: both are reflected in the same edge's wfull, wlevel and wafull.
- Wrap-around: wbin wraps from 2^(ADDRSIZE+1)-1 to 0. wptr wraps from Gray 100…0 to 0. Full and level stay correct because all arithmetic is modulo 2^(ADDRSIZE+1).
- wptr changes by exactly one bit per accepted write, and never changes on other cycles.

## Timing
- Reset: wrst high at an edge forces wbin = 0, wptr = 0, waddr = 0, wfull = 0, wafull = 0, wlevel = 0, woverflow = 0.
  - winc is ignored during reset.
  - Reset mid-operation discards all state in one edge.
  - The read side must be reset in the same system reset.
- wen is combinational in the same cycle as winc. RAM data and address are captured at the same edge that advances wbin.
- Write-to-full latency: wfull is high after the edge that accepts the 2^ADDRSIZE-th unread entry, so no extra write slips in.
- Flag response to wq2_rptr: wfull, wafull and wlevel update one edge after wq2_rptr changes. The total read-to-write delay is 2 wclk (synchroniser) + 1 wclk.
- wptr is a pure register output with no combinational path, so it is safe for the CDC.

## Test plan
- Reset: hold wrst for 2 cycles with winc = 1 -> all outputs 0, wen = 0 only if wfull; after release waddr = 0.
- Fill (ADDRSIZE=4, wq2_rptr=0): 16 consecutive winc -> waddr steps 0..15 and wptr follows 0,1,3,2,6,…; wafull rises after the 12th write; after the 16th write wfull = 1, wlevel = 16, wptr = 5'b11000.
- Overflow: 3 further winc while full -> wen = 0, wptr stays 5'b11000, woverflow = 1 and remains 1 after winc drops.
- Drain: wq2_rptr = 5'b00110 (bin 4) -> next edge wfull = 0, wlevel = 12, wafull = 1; then 5'b00111 -> wlevel = 11, wafull = 0.
- Wrap and simultaneous events: keep the read side 4 behind while writing 40 entries -> wptr passes 5'b10000 -> 5'b00000; wlevel stays 4 on edges where a write and a read pointer step coincide; wfull is never set.
- Reset mid-operation: with wfull = 1 and woverflow = 1, pulse wrst for 1 cycle -> next edge wptr = 0, wfull = 0, wlevel = 0, woverflow = 0; the following winc writes waddr = 0.

Source files
------------

// File: rtl/async_fifo_wptr_full_if.sv
// rtl/async_fifo_wptr_full_if.sv - write-side client/pointer bundle for the dual-clock FIFO write logic
interface async_fifo_wptr_full_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  modport master (
    output winc, wq2_rptr,
    input  wen, waddr, wptr, wfull, wafull, wlevel, woverflow
  );

  modport slave (
    input  winc, wq2_rptr,
    output wen, waddr, wptr, wfull, wafull, wlevel, woverflow
  );
endinterface

// File: rtl/async_fifo_wptr_full.sv
// rtl/async_fifo_wptr_full.sv - write pointer, Gray pointer and full/level flags of the dual-clock FIFO
module async_fifo_wptr_full #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input logic                   wclk,
  input logic                   wrst,
  async_fifo_wptr_full_if.slave bus
);
  localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q, wfull_d;
  logic              wafull_q, wafull_d;
  logic              woverflow_q, woverflow_d;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] rptr_full;
  logic              wen;

  assign wen = bus.winc & ~wfull_q;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(bus.wq2_rptr >> i);
    end
  end

  assign rptr_full = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};

  always_comb begin
    wbin_d      = wbin_q + (ADDRSIZE+1)'(wen);
    wptr_d      = (wbin_d >> 1) ^ wbin_d;
    wfull_d     = (wptr_d == rptr_full);
    wlevel_d    = wbin_d - rbin_s;
    wafull_d    = (wlevel_d >= AFULL_LVL);
    woverflow_d = woverflow_q | (bus.winc & wfull_q);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q      <= '0;
      wptr_q      <= '0;
      wlevel_q    <= '0;
      wfull_q     <= 1'b0;
      wafull_q    <= 1'b0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wptr_q      <= wptr_d;
      wlevel_q    <= wlevel_d;
      wfull_q     <= wfull_d;
      wafull_q    <= wafull_d;
      woverflow_q <= woverflow_d;
    end
  end

  assign bus.wen       = wen;
  assign bus.waddr     = wbin_q[ADDRSIZE-1:0];
  assign bus.wptr      = wptr_q;
  assign bus.wfull     = wfull_q;
  assign bus.wafull    = wafull_q;
  assign bus.wlevel    = wlevel_q;
  assign bus.woverflow = woverflow_q;
endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// tb/tb_async_fifo_wptr_full.sv - directed vector bench for async_fifo_wptr_full
module tb_async_fifo_wptr_full;
  localparam int AW = 4;

  typedef struct {
    logic       rst;
    logic       inc;
    logic [4:0] rptr;
    logic       chk_wen;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wlevel;
    logic       wovf;
  } vec_t;

  logic wclk = 1'b0;
  logic wrst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t v[24];
  logic [4:0] gtab[17];
  int   nv;

  async_fifo_wptr_full_if #(.ADDRSIZE(AW)) bus ();

  async_fifo_wptr_full #(.ADDRSIZE(AW), .AFULL_THRESH(12)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus.slave)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic inc, input logic [4:0] rptr);
    wrst = rst;
    bus.winc = inc;
    bus.wq2_rptr = rptr;
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic vec_t mk(input logic rst, input logic inc, input logic [4:0] rptr,
                              input logic chk_wen, input logic wen, input logic [3:0] waddr,
                              input logic [4:0] wptr, input logic wfull, input logic wafull,
                              input logic [4:0] wlevel, input logic wovf);
    vec_t r;
    r.rst = rst; r.inc = inc; r.rptr = rptr; r.chk_wen = chk_wen; r.wen = wen;
    r.waddr = waddr; r.wptr = wptr; r.wfull = wfull; r.wafull = wafull;
    r.wlevel = wlevel; r.wovf = wovf;
    return r;
  endfunction

  initial begin
    gtab = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101,
             5'b00100, 5'b01100, 5'b01101, 5'b01111, 5'b01110, 5'b01010, 5'b01011,
             5'b01001, 5'b01000, 5'b11000};
    nv = 0;
    // reset held two edges with winc high
    v[nv++] = mk(1, 1, 5'd0, 0, 0, 4'd0, 5'd0, 0, 0, 5'd0, 0);
    v[nv++] = mk(1, 1, 5'd0, 1, 1, 4'd0, 5'd0, 0, 0, 5'd0, 0);
    // fill 16 entries with the read side idle
    for (int i = 1; i <= 16; i++) begin
      v[nv++] = mk(0, 1, 5'd0, 1, 1, 4'(i), gtab[i], (i == 16), (i >= 12), 5'(i), 0);
    end
    // writes while full are dropped and flag overflow
    for (int i = 0; i < 3; i++) begin
      v[nv++] = mk(0, 1, 5'd0, 1, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    end
    v[nv++] = mk(0, 0, 5'd0, 1, 0, 4'd0, 5'b11000, 1, 1, 5'd16, 1);
    // drain: read pointer reaches 4 then 5
    v[nv++] = mk(0, 0, 5'b00110, 1, 0, 4'd0, 5'b11000, 0, 1, 5'd12, 1);
    v[nv++] = mk(0, 0, 5'b00111, 1, 0, 4'd0, 5'b11000, 0, 0, 5'd11, 1);

    for (int i = 0; i < nv; i++) begin
      wrst = v[i].rst;
      bus.winc = v[i].inc;
      bus.wq2_rptr = v[i].rptr;
      #1;
      if (v[i].chk_wen) chk($sformatf("v%0d wen", i), 32'(bus.wen), 32'(v[i].wen));
      @(posedge wclk);
      #1;
      chk($sformatf("v%0d waddr", i),     32'(bus.waddr),     32'(v[i].waddr));
      chk($sformatf("v%0d wptr", i),      32'(bus.wptr),      32'(v[i].wptr));
      chk($sformatf("v%0d wfull", i),     32'(bus.wfull),     32'(v[i].wfull));
      chk($sformatf("v%0d wafull", i),    32'(bus.wafull),    32'(v[i].wafull));
      chk($sformatf("v%0d wlevel", i),    32'(bus.wlevel),    32'(v[i].wlevel));
      chk($sformatf("v%0d woverflow", i), 32'(bus.woverflow), 32'(v[i].wovf));
    end

    // wrap: read side trails by 4 while 40 entries are written
    cyc(1, 0, 5'd0);
    for (int k = 1; k <= 4; k++) cyc(0, 1, 5'd0);
    chk("wrap prefill wlevel", 32'(bus.wlevel), 32'd4);
    for (int k = 5; k <= 40; k++) begin
      cyc(0, 1, gray(k - 4));
      chk($sformatf("wrap k%0d wlevel", k), 32'(bus.wlevel), 32'd4);
      chk($sformatf("wrap k%0d wfull", k),  32'(bus.wfull),  32'd0);
      chk($sformatf("wrap k%0d wptr", k),   32'(bus.wptr),   32'(gray(k % 32)));
      if (k == 31) chk("wrap wptr top", 32'(bus.wptr), 32'b10000);
      if (k == 32) chk("wrap wptr zero", 32'(bus.wptr), 32'b00000);
    end

    // refill to full from wbin=8 (mod 32) with read at 4, then overflow and reset
    for (int j = 0; j < 12; j++) cyc(0, 1, gray(4));
    chk("refill wfull", 32'(bus.wfull), 32'd1);
    chk("refill wlevel", 32'(bus.wlevel), 32'd16);
    cyc(0, 1, gray(4));
    chk("refill woverflow", 32'(bus.woverflow), 32'd1);
    chk("refill wptr hold", 32'(bus.wptr), 32'b11110);
    cyc(1, 1, 5'd0);
    chk("midrst wptr", 32'(bus.wptr), 32'd0);
    chk("midrst wfull", 32'(bus.wfull), 32'd0);
    chk("midrst wafull", 32'(bus.wafull), 32'd0);
    chk("midrst wlevel", 32'(bus.wlevel), 32'd0);
    chk("midrst woverflow", 32'(bus.woverflow), 32'd0);
    wrst = 1'b0;
    bus.winc = 1'b1;
    bus.wq2_rptr = 5'd0;
    #1;
    chk("post-rst wen", 32'(bus.wen), 32'd1);
    chk("post-rst waddr", 32'(bus.waddr), 32'd0);
    @(posedge wclk);
    #1;
    chk("post-rst waddr next", 32'(bus.waddr), 32'd1);
    chk("post-rst wptr next", 32'(bus.wptr), 32'b00001);
    bus.winc = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
